// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - funct3 access-size/sign codes
//   - FSM state encoding
//   - access-size and alignment helpers
package mem_stage_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } lsuState_t;

   // Byte-sized access (signed or unsigned).
   function automatic logic isByteAccess(input logic [2:0] funct3);
      return (funct3 == F3_B) || (funct3 == F3_BU);
   endfunction

   // Halfword-sized access (signed or unsigned).
   function automatic logic isHalfAccess(input logic [2:0] funct3);
      return (funct3 == F3_H) || (funct3 == F3_HU);
   endfunction

   // Anything that is not a byte or halfword code behaves as a word,
   // including the undefined codes 011, 110 and 111.
   function automatic logic isMisaligned(input logic [2:0] funct3,
                                         input logic [1:0] lowAddr);
      if (isByteAccess(funct3))
         return 1'b0;
      else if (isHalfAccess(funct3))
         return lowAddr[0];
      else
         return (lowAddr != 2'b00);
   endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load alignment and extension.
//   word    : 32-bit word read from DataRam
//   lowAddr : byte address bits [1:0]
//   funct3  : access size/sign code
//   loadData: selected byte/halfword, sign- or zero-extended; whole word for W
module lsu_load_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lowAddr,
   input  logic [2:0]  funct3,
   output logic [31:0] loadData
);

   logic [31:0] shifted;

   // Bring the addressed lane down to bit 0; for halfwords lowAddr[0] is 0
   // on every aligned access, so the same shift serves both sizes.
   assign shifted = word >> {lowAddr, 3'b000};

   always_comb begin
      loadData = word;
      case (funct3)
         F3_B:    loadData = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   loadData = {24'h000000, shifted[7:0]};
         F3_H:    loadData = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   loadData = {16'h0000, shifted[15:0]};
         default: loadData = word;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit in front of a word-wide DataRam
// (asynchronous read, write on the clock edge).
//   clk, reset           : clock, asynchronous active-high reset
//   MemRead_mem/...      : EX/MEM register outputs (control, funct3, address, store data)
//   ram_a/ram_d/ram_we   : DataRam word address, write data, write enable
//   ram_spo              : DataRam asynchronous read data
//   MemDout_mem          : extended load result to MEM/WB
//   MemStall             : holds PC..EX/MEM during the first cycle of a sub-word store
//   misalign_err/_addr   : sticky record of the first misaligned access
//   err_clr              : synchronous clear of the sticky record
// Sub-word stores read the old word in IDLE, merge the new lanes into
// mergeReg, and write the merged word from RMW_WR on the following cycle.
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead_mem,
   input  logic              MemWrite_mem,
   input  logic [2:0]        funct3_mem,
   input  logic [31:0]       ALUResult_mem,
   input  logic [31:0]       MemWriteData_mem,
   output logic [ADDR_W-1:0] ram_a,
   output logic [31:0]       ram_d,
   output logic              ram_we,
   input  logic [31:0]       ram_spo,
   output logic [31:0]       MemDout_mem,
   output logic              MemStall,
   output logic              misalign_err,
   output logic [31:0]       misalign_addr,
   input  logic              err_clr
);

   lsuState_t         stateReg, stateNext;
   logic [31:0]       mergeReg, mergeNext;
   logic [ADDR_W-1:0] addrReg, addrNext;

   logic              accessValid;
   logic              misaligned;
   logic              subWord;
   logic              byteAccess;
   logic [31:0]       loadData;
   logic [31:0]       storeRep;
   logic [3:0]        laneSel;
   logic [31:0]       mergedWord;
   logic              ramWeRaw;
   logic              stallRaw;

   assign accessValid = MemRead_mem | MemWrite_mem;
   assign byteAccess  = isByteAccess(funct3_mem);
   assign subWord     = byteAccess | isHalfAccess(funct3_mem);
   assign misaligned  = accessValid & isMisaligned(funct3_mem, ALUResult_mem[1:0]);

   lsu_load_align uLoadAlign (
      .word     (ram_spo),
      .lowAddr  (ALUResult_mem[1:0]),
      .funct3   (funct3_mem),
      .loadData (loadData)
   );

   // Replicate the store data across all lanes so each lane just picks
   // between new data and the old RAM byte.
   assign storeRep = byteAccess ? {4{MemWriteData_mem[7:0]}}
                                : {2{MemWriteData_mem[15:0]}};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign laneSel[gi] = byteAccess ? (ALUResult_mem[1:0] == 2'(gi))
                                         : (ALUResult_mem[1] == 1'(gi / 2));
         assign mergedWord[8*gi +: 8] = laneSel[gi] ? storeRep[8*gi +: 8]
                                                    : ram_spo[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      stateNext   = stateReg;
      mergeNext   = mergeReg;
      addrNext    = addrReg;
      ram_a       = ALUResult_mem[ADDR_W+1:2];
      ram_d       = MemWriteData_mem;
      ramWeRaw    = 1'b0;
      stallRaw    = 1'b0;
      MemDout_mem = 32'h0;
      case (stateReg)
         IDLE: begin
            if (!accessValid) begin
               MemDout_mem = ram_spo;
            end else if (misaligned) begin
               // Suppressed: no write, no stall, zero result.
               MemDout_mem = 32'h0;
            end else if (MemWrite_mem) begin
               // A store wins over a simultaneous load; result stays zero.
               if (subWord) begin
                  stallRaw  = 1'b1;
                  mergeNext = mergedWord;
                  addrNext  = ALUResult_mem[ADDR_W+1:2];
                  stateNext = RMW_WR;
               end else begin
                  ramWeRaw = 1'b1;
               end
            end else begin
               MemDout_mem = loadData;
            end
         end
         RMW_WR: begin
            ram_a     = addrReg;
            ram_d     = mergeReg;
            ramWeRaw  = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Gate with reset so an in-flight RMW write is abandoned and no stall
   // is requested while reset is held.
   assign ram_we   = ramWeRaw & ~reset;
   assign MemStall = stallRaw & ~reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateReg <= IDLE;
         mergeReg <= 32'h0;
         addrReg  <= '0;
      end else begin
         stateReg <= stateNext;
         mergeReg <= mergeNext;
         addrReg  <= addrNext;
      end
   end

   // A fresh misaligned capture takes priority over a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         misalign_err  <= 1'b0;
         misalign_addr <= 32'h0;
      end else if (stateReg == IDLE && misaligned && (!misalign_err || err_clr)) begin
         misalign_err  <= 1'b1;
         misalign_addr <= ALUResult_mem;
      end else if (err_clr) begin
         misalign_err  <= 1'b0;
         misalign_addr <= 32'h0;
      end
   end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit in the MEM stage, between the EX/MEM register outputs and the word-wide DataRam, which has asynchronous read and write on the clock edge.
- Adds byte and halfword access: LB/LH/LW/LBU/LHU and SB/SH/SW.
- Sub-word stores use a two-cycle read-modify-write sequence that stalls the front of the pipeline.
- Detects misaligned accesses and records the first one in sticky error status.

Parameters:
ADDR_W, 6, number of word-address bits driven to DataRam; the word index is addr[ADDR_W+1:2].

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
MemRead_mem  in  1  load in MEM stage
MemWrite_mem  in  1  store in MEM stage
funct3_mem  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResult_mem  in  32  byte address
MemWriteData_mem  in  32  store data, right-justified
ram_a  out  ADDR_W  DataRam word address
ram_d  out  32  DataRam write data
ram_we  out  1  DataRam write enable
ram_spo  in  32  DataRam async read data
MemDout_mem  out  32  extended load result, to MEMWB
MemStall  out  1  hold PC, IFID, IDEX and EXMEM; bubble MEMWB
misalign_err  out  1  sticky misalignment flag
misalign_addr  out  32  byte address of the first misaligned access
err_clr  in  1  synchronous clear of misalign_err and misalign_addr

Behaviour:
- Alignment rules:
  - H/HU accesses are misaligned when addr[0]=1.
  - W accesses are misaligned when addr[1:0]!=0.
  - B/BU accesses are never misaligned.
- State machine: IDLE and RMW_WR. Reset forces IDLE, misalign_err=0, misalign_addr=0, merge_reg=0.
- Reset behaviour:
  - During reset, ram_we=0 and MemStall=0.
  - A reset taken while in RMW_WR abandons the write: no partial store reaches RAM.
- Outputs in IDLE:
  - ram_a = ALUResult_mem[ADDR_W+1:2].
  - Aligned SW: ram_we=1 and ram_d=MemWriteData_mem in the same cycle; no stall.
  - Aligned SB/SH:
    - MemStall=1 (combinational) and ram_we=0.
    - Latch merge_reg = ram_spo with the addressed byte lanes replaced by MemWriteData_mem[7:0] or [15:0].
    - Latch the word address into addr_reg, then go to RMW_WR.
  - Aligned load, zero added latency:
    - Select the byte at lane addr[1:0], or the halfword at lane addr[1].
    - B/H sign-extend; BU/HU zero-extend; W passes the word through.
  - No MemRead or MemWrite: MemDout_mem = ram_spo; no write.
- Outputs in RMW_WR:
  - ram_a=addr_reg, ram_d=merge_reg, ram_we=1, MemStall=0.
  - The module inputs are ignored in this state; the EX/MEM register still holds the same store.
  - Always return to IDLE on the next edge.
- Misaligned access, in IDLE only:
  - No write; MemDout_mem=0; no stall.
  - If misalign_err=0, set misalign_err=1 and capture ALUResult_mem in misalign_addr.
  - Later misaligned accesses do not overwrite misalign_addr.
  - err_clr=1 clears both on the clock edge. If a misaligned access occurs in the same cycle, the new capture wins.
- MemRead and MemWrite both high: treated as a store, and MemDout_mem=0.
- Unknown funct3 (011, 110, 111): treated as W.
- Read-after-write: a load in the cycle after RMW_WR, or after an SW, to the same word sees the new data, since the RAM writes on the edge and reads asynchronously.
- Throughput:
  - SW and loads: one per cycle.
  - SB/SH: one per two cycles.
  - Back-to-back SB instructions each take the full IDLE→RMW_WR sequence.

Decomposition:
- Shared package holds:
  - funct3 constants: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - The state encoding: IDLE=1'b0, RMW_WR=1'b1.
- One combinational sub-module, lsu_load_align, takes (word, addr[1:0], funct3) and returns the extended load data.
- Store-lane merge and the FSM stay in mem_stage_lsu.

Test Plan:
- SW 0x12345678 to 0x10, then LW 0x10: ram_we=1 in the store cycle, MemStall=0; load returns 0x12345678.
- With word 0x10=0x12345678, SB 0xAB to 0x11: MemStall=1 for one cycle, then ram_we=1 with ram_d=0x1234AB78. A following LB 0x11 returns 0xFFFFFFAB; LBU returns 0x000000AB.
- SH 0x8001 to 0x12, then LH 0x12 → 0xFFFF8001 and LHU 0x12 → 0x00008001; the word reads 0x80010000 when bits [15:0] were 0.
- LW 0x13: MemDout_mem=0, misalign_err=1, misalign_addr=0x13. A subsequent SH 0x15 leaves misalign_addr=0x13 and performs no write. err_clr clears both to 0.
- Assert reset while in RMW_WR for SB 0xFF to 0x20 (old word 0): state returns to IDLE, ram_we=0, and after reset LW 0x20 returns 0.
- SB to 0x30 immediately followed by SB to 0x31: two stall cycles total; the final word has both bytes merged, e.g. 0x0000BBAA.
